// File: rtl/fifo_in_buffer.sv
// Receive-side buffer for the fifo_in stream: accepts words over valid/ready,
// holds them in a circular register array, and replays them in order downstream.
module fifo_in_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int AFULL_LVL  = DEPTH - 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [DATA_WIDTH-1:0]        data_in,
    input  logic                         data_in_vld,
    output logic                         data_in_rdy,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic                         data_out_vld,
    input  logic                         data_out_rdy,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         almost_full
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic                  rdy_q;
    logic                  push;
    logic                  pop;

    // Handshake flags come only from registered state, so neither valid nor
    // ready input has a combinational path to the opposite side.
    assign data_in_rdy  = rdy_q && (level_q != LW'(DEPTH));
    assign data_out_vld = (level_q != '0);
    assign data_out     = mem_q[rd_ptr_q];
    assign level        = level_q;
    assign almost_full  = (level_q >= LW'(AFULL_LVL));

    assign push = data_in_vld && data_in_rdy;
    assign pop  = data_out_vld && data_out_rdy;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !push) begin
            level_d = level_q - LW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            rdy_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            rdy_q    <= 1'b1;
        end
    end

    // Storage is deliberately left out of reset; stale words are unreachable
    // once the pointers and level are cleared.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

endmodule
